// File: rtl/aes_iter_core.sv
// ---------------------------------------------------------------------------
// aes_iter_core
//
// Iterative AES encryption core that runs one round per clock. The round keys
// are produced on the fly from a small key window register, so the full key
// schedule is never stored. KEY_BITS selects AES-128 (10 rounds) or AES-256
// (14 rounds). One block can be in flight at a time.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   in_valid    plaintext/key are presented
//   in_ready    core accepts a block this cycle (IDLE, or DONE while the
//               result is being taken)
//   plaintext   128-bit input block, byte 0 in [127:120]
//   key         KEY_BITS cipher key, w[0] in the top 32 bits
//   out_valid   ciphertext is valid
//   out_ready   consumer takes the ciphertext
//   ciphertext  128-bit result, same byte order as plaintext
//   busy        high while rounds are being computed
// ---------------------------------------------------------------------------
module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plaintext,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        ciphertext,
    output logic                busy
);

    localparam int         NR   = (KEY_BITS == 128) ? 10 : 14;
    localparam logic [3:0] NR_L = 4'(NR);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Datapath functions
    // -----------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n of the block sits at row n%4, column n/4. Row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8 * (4 * c + rw) -: 8] = s[127 - 8 * (4 * ((c + rw) % 4) + rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          round_q;
    logic [127:0]        blk_q;
    logic [KEY_BITS-1:0] key_q;
    logic [127:0]        ct_q;
    logic                out_valid_q;

    logic                accept;
    logic                last_round;

    assign accept     = in_valid && in_ready;
    assign last_round = (round_q == NR_L);

    // -----------------------------------------------------------------------
    // Round datapath
    // -----------------------------------------------------------------------
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] rk_cur;
    logic [KEY_BITS-1:0] key_nxt;

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        assign sb[127 - 8 * gi -: 8] = sbox(blk_q[127 - 8 * gi -: 8]);
    end

    assign sr = shift_rows(sb);

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
        assign mc[127 - 32 * gi -: 32] = mix_column(sr[127 - 32 * gi -: 32]);
    end

    // -----------------------------------------------------------------------
    // On-the-fly key schedule.
    // key_q holds the words that precede the round key needed in the current
    // round; rk_cur is that round key and key_nxt is the window to keep for
    // the following round.
    // -----------------------------------------------------------------------
    if (KEY_BITS == 128) begin : g_ks128
        // Window holds RK[r-1]; RK[r] is derived from it in round r.
        logic [31:0] w0, w1, w2, w3;
        assign w0 = key_q[127:96] ^ sub_word(rot_word(key_q[31:0])) ^ {rcon(round_q), 24'h0};
        assign w1 = key_q[95:64] ^ w0;
        assign w2 = key_q[63:32] ^ w1;
        assign w3 = key_q[31:0]  ^ w2;
        assign rk_cur  = {w0, w1, w2, w3};
        assign key_nxt = {w0, w1, w2, w3};
    end else if (KEY_BITS == 256) begin : g_ks256
        // Window holds w[4(r-1) .. 4r+3]; its lower half is RK[r] directly.
        // The four words appended for the next round start at i = 4r+4,
        // which is a multiple of 8 exactly when r is odd.
        logic        rot_step;
        logic [3:0]  rc_idx;
        logic [31:0] f;
        logic [31:0] n0, n1, n2, n3;
        assign rot_step = round_q[0];
        assign rc_idx   = 4'((5'(round_q) + 5'd1) >> 1);
        assign f        = rot_step ? (sub_word(rot_word(key_q[31:0])) ^ {rcon(rc_idx), 24'h0})
                                   : sub_word(key_q[31:0]);
        assign n0 = key_q[255:224] ^ f;
        assign n1 = key_q[223:192] ^ n0;
        assign n2 = key_q[191:160] ^ n1;
        assign n3 = key_q[159:128] ^ n2;
        assign rk_cur  = key_q[127:0];
        assign key_nxt = {key_q[127:0], n0, n1, n2, n3};
    end else begin : g_bad_key
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (last_round) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = accept ? S_ROUND : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. in_ready is held low while reset is asserted so nothing
    // is offered as accepted during the reset cycle.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = !rst;
            S_ROUND: busy     = 1'b1;
            S_DONE:  in_ready = !rst && out_ready;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Block state, key window, round counter and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q       <= '0;
            key_q       <= '0;
            round_q     <= '0;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                blk_q   <= plaintext ^ key[KEY_BITS-1 -: 128];
                key_q   <= key;
                round_q <= 4'd1;
            end else if (state_q == S_ROUND) begin
                if (last_round) begin
                    // Final round skips MixColumns; counter stays at NR.
                    ct_q <= sr ^ rk_cur;
                end else begin
                    blk_q   <= mc ^ rk_cur;
                    key_q   <= key_nxt;
                    round_q <= round_q + 4'd1;
                end
            end

            if (state_q == S_ROUND && last_round) begin
                out_valid_q <= 1'b1;
            end else if (state_q == S_DONE && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// ---------------------------------------------------------------------------
// tb_aes_iter_core
//
// Drives one AES-128 and one AES-256 instance. Known-answer vectors come from
// a table; randomized blocks are checked against a reference model that
// derives the S-box from GF(2^8) inversion and expands the whole key
// schedule up front. Hand-written sequences cover backpressure, back-to-back
// accept and reset in mid-flight.
// ---------------------------------------------------------------------------
module tb_aes_iter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [1:0]        in_valid_s;
    logic [1:0]        out_ready_s;
    logic [1:0][127:0] pt_s;
    logic [127:0]      key0;
    logic [255:0]      key1;
    wire  [1:0]        in_ready_s;
    wire  [1:0]        out_valid_s;
    wire  [1:0]        busy_s;
    wire  [1:0][127:0] ct_s;

    aes_iter_core #(.KEY_BITS(128)) dut128 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_s[0]),
        .in_ready   (in_ready_s[0]),
        .plaintext  (pt_s[0]),
        .key        (key0),
        .out_valid  (out_valid_s[0]),
        .out_ready  (out_ready_s[0]),
        .ciphertext (ct_s[0]),
        .busy       (busy_s[0])
    );

    aes_iter_core #(.KEY_BITS(256)) dut256 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_s[1]),
        .in_ready   (in_ready_s[1]),
        .plaintext  (pt_s[1]),
        .key        (key1),
        .out_valid  (out_valid_s[1]),
        .out_ready  (out_ready_s[1]),
        .ciphertext (ct_s[1]),
        .busy       (busy_s[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %032h required %032h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    // nk = 4 or 8 key words; the key is read from the top of k.
    function automatic logic [127:0] aes_model(input int nk, input logic [255:0] k, input logic [127:0] pt);
        logic [31:0] w [60];
        logic [7:0]  st [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i - nk] ^ tmp;
        end
        for (int n = 0; n < 16; n++) st[n] = pt[127 - 8 * n -: 8] ^ w[n / 4][31 - 8 * (n % 4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    t[4 * c + rw] = sb_tab[st[4 * ((c + rw) % 4) + rw]];
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    st[4*c+0] = gmul(8'h02, t[4*c+0]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    st[4*c+1] = t[4*c+0] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    st[4*c+2] = t[4*c+0] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    st[4*c+3] = gmul(8'h03, t[4*c+0]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int rw = 0; rw < 4; rw++) st[4*c+rw] = t[4*c+rw];
                end
                for (int rw = 0; rw < 4; rw++)
                    st[4*c+rw] = st[4*c+rw] ^ w[4*r + c][31 - 8 * rw -: 8];
            end
        end
        for (int n = 0; n < 16; n++) res[127 - 8 * n -: 8] = st[n];
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_key(input int k, input logic [255:0] kv);
        if (k == 0) key0 = kv[255:128];
        else        key1 = kv;
    endtask

    // Runs one block on instance k (0: AES-128, 1: AES-256). hold = cycles of
    // out_ready=0 after the result appears; scramble = change inputs every
    // cycle while the block is in flight.
    task automatic run_block(input int k, input logic [255:0] kv, input logic [127:0] pt,
                             input logic [127:0] exp, input int hold, input bit scramble,
                             input string name);
        int cyc;
        int nr;
        bit stable;
        nr  = (k == 0) ? 10 : 14;
        cyc = 0;
        while (!in_ready_s[k] && cyc < 50) begin
            tick();
            cyc++;
        end
        chk_bit($sformatf("%s ready", name), in_ready_s[k], 1'b1);
        pt_s[k] = pt;
        set_key(k, kv);
        in_valid_s[k]  = 1'b1;
        out_ready_s[k] = (hold == 0);
        tick();
        in_valid_s[k] = 1'b0;
        cyc = 0;
        while (!out_valid_s[k] && cyc < 40) begin
            if (scramble) begin
                pt_s[k] = rand128();
                set_key(k, {rand128(), rand128()});
            end
            tick();
            cyc++;
        end
        chk_int($sformatf("%s latency", name), cyc, nr);
        chk_val($sformatf("%s ct", name), ct_s[k], exp);
        $display("blk %s aes%0d pt=%032h ct=%032h lat=%0d hold=%0d", name, (k == 0) ? 128 : 256,
                 pt, ct_s[k], cyc, hold);
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (out_valid_s[k] !== 1'b1 || ct_s[k] !== exp || in_ready_s[k] !== 1'b0) stable = 1'b0;
            end
            chk_bit($sformatf("%s hold stable", name), stable, 1'b1);
            out_ready_s[k] = 1'b1;
        end
        tick();
        chk_bit($sformatf("%s out_valid drop", name), out_valid_s[k], 1'b0);
        chk_val($sformatf("%s ct kept", name), ct_s[k], exp);
    endtask

    typedef struct {
        int           k;
        logic [255:0] kv;
        logic [127:0] pt;
        logic [127:0] ct;
        bit           scramble;
    } vec_t;

    vec_t vecs [4];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit flag;
        logic [255:0] rk;
        logic [127:0] rp;
        int k;

        build_sbox();
        rst         = 1'b1;
        in_valid_s  = '0;
        out_ready_s = 2'b11;
        pt_s        = '0;
        key0        = '0;
        key1        = '0;

        vecs[0] = '{0, {K1, 128'h0}, P1, C1, 1'b0};
        vecs[1] = '{0, {K2, 128'h0}, P2, C2, 1'b1};
        vecs[2] = '{0, 256'h0, 128'h0, C0, 1'b0};
        vecs[3] = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    P1, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1};

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk_bit($sformatf("reset in_ready[%0d]", i), in_ready_s[i], 1'b0);
            chk_bit($sformatf("reset out_valid[%0d]", i), out_valid_s[i], 1'b0);
            chk_bit($sformatf("reset busy[%0d]", i), busy_s[i], 1'b0);
            chk_val($sformatf("reset ct[%0d]", i), ct_s[i], 128'h0);
        end
        rst = 1'b0;
        #1;
        chk_bit("post-reset in_ready128", in_ready_s[0], 1'b1);
        chk_bit("post-reset in_ready256", in_ready_s[1], 1'b1);

        // Known-answer vectors
        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].k, vecs[v].kv, vecs[v].pt, vecs[v].ct, 0, vecs[v].scramble,
                      $sformatf("kat%0d", v));
        end

        // Backpressure: result held for 20 cycles, new request refused
        key0 = K1; pt_s[0] = P1; out_ready_s[0] = 1'b0; in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        cyc = 0;
        while (!out_valid_s[0] && cyc < 40) begin tick(); cyc++; end
        chk_int("bp first latency", cyc, 10);
        chk_val("bp first ct", ct_s[0], C1);
        key0 = K2; pt_s[0] = P2; in_valid_s[0] = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid_s[0] !== 1'b1 || ct_s[0] !== C1 || in_ready_s[0] !== 1'b0 || busy_s[0] !== 1'b0)
                flag = 1'b0;
        end
        chk_bit("bp hold stable", flag, 1'b1);
        out_ready_s[0] = 1'b1;
        #1;
        chk_bit("bp release in_ready", in_ready_s[0], 1'b1);
        tick();
        in_valid_s[0] = 1'b0;
        chk_bit("bp accept busy", busy_s[0], 1'b1);
        chk_bit("bp out_valid drop", out_valid_s[0], 1'b0);
        chk_val("bp ct kept", ct_s[0], C1);
        cyc = 0;
        while (!out_valid_s[0] && cyc < 40) begin tick(); cyc++; end
        chk_int("bp second latency", cyc, 10);
        chk_val("bp second ct", ct_s[0], C2);
        $display("blk bp aes128 ct=%032h lat=%0d", ct_s[0], cyc);

        // Back-to-back accept in the DONE cycle: results NR+1 cycles apart
        key0 = 128'h0; pt_s[0] = 128'h0; in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        cyc = 1;
        while (!out_valid_s[0] && cyc < 40) begin tick(); cyc++; end
        chk_int("b2b spacing", cyc, 11);
        chk_val("b2b ct", ct_s[0], C0);
        $display("blk b2b aes128 ct=%032h spacing=%0d", ct_s[0], cyc);
        tick();

        // Reset in the middle of round 5
        key0 = K1; pt_s[0] = P1; in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        repeat (4) tick();
        chk_bit("abort busy before rst", busy_s[0], 1'b1);
        rst = 1'b1;
        tick();
        chk_bit("abort out_valid", out_valid_s[0], 1'b0);
        chk_bit("abort busy", busy_s[0], 1'b0);
        chk_val("abort ct", ct_s[0], 128'h0);
        chk_bit("abort in_ready during rst", in_ready_s[0], 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("abort in_ready after rst", in_ready_s[0], 1'b1);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid_s[0] !== 1'b0) flag = 1'b1;
        end
        chk_bit("abort no stale output", flag, 1'b0);
        $display("blk abort aes128 ct=%032h", ct_s[0]);

        // Randomized blocks against the reference model
        for (int i = 0; i < 12; i++) begin
            k  = i % 2;
            rk = {rand128(), rand128()};
            rp = rand128();
            run_block(k, rk, rp, aes_model((k == 0) ? 4 : 8, rk, rp), int'($urandom_range(0, 3)),
                      1'b1, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
